fir_out_serializer: RTL
=======================

FIR_OUT_SERIALIZER -- requirements
Module: fir_out_serializer

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 64: width of the filter output sample.
REQ-002 Parameter DATA_OUT_WIDTH, default 16: width of the serialized sample.
REQ-003 Parameter SHIFT, default 31: arithmetic right-shift applied to the input (Q-format alignment); legal range 1..DATA_IN_WIDTH-DATA_OUT_WIDTH.
REQ-004 Parameter FIFO_DEPTH, default 8: sample buffer depth, power of two.
REQ-005 Parameter BIT_DIV, default 4: clk cycles per serial bit, even, >=2.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_data  input  DATA_IN_WIDTH  signed filter output sample.
REQ-009 in_valid  input  1  in_data valid this cycle.
REQ-010 in_ready  output  1  block can accept a sample this cycle.
REQ-011 sck  output  1  serial bit clock.
REQ-012 ws  output  1  word-start strobe, high for the MSB bit period.
REQ-013 sdo  output  1  serial data, MSB first.
REQ-014 sat_flag  output  1  sticky flag: at least one sample saturated.
REQ-015 ovf_cnt  output  8  count of dropped samples (in_valid & !in_ready), saturating at 255.

Function
REQ-016 Scaling: r = (in_data + 2^(SHIFT-1)) >>> SHIFT (round half up, full-width arithmetic, no intermediate overflow).
REQ-017 Saturation: r > 32767 -> 32767; r < -32768 -> -32768; either case sets sat_flag next cycle.
REQ-018 Handshake: sample accepted when in_valid && in_ready; scaled value written to FIFO in the same edge.
REQ-019 in_ready = !fifo_full, combinational from registered count; no push when full, even if a pop occurs that cycle.
REQ-020 FIFO: read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH; simultaneous push and pop leaves count unchanged.
REQ-021 Dropped sample (in_valid && !in_ready) increments ovf_cnt; holds at 255.
REQ-022 FSM states: IDLE, LOAD, SHIFT.
REQ-023 IDLE: sck=0, ws=0, sdo=0; FIFO non-empty -> LOAD.
REQ-024 LOAD (1 cycle): pop FIFO head into shift register, bit index=15, divider=0 -> SHIFT.
REQ-025 SHIFT: divider counts 0..BIT_DIV-1; sck = (divider >= BIT_DIV/2); sdo = shift_reg[bit index]; ws = (bit index == 15).
REQ-026 sdo/ws change only at divider==0 (sck falling edge); stable while sck high.
REQ-027 At divider==BIT_DIV-1 with bit index>0: bit index decrements.
REQ-028 At divider==BIT_DIV-1 with bit index==0: FIFO non-empty -> pop next word directly, bit index=15, stay in SHIFT (no gap); FIFO empty -> IDLE.
REQ-029 Latency: sample accepted at edge N into empty FIFO with FSM in IDLE -> LOAD at N+1, MSB on sdo with ws=1 from edge N+2.
REQ-030 One word occupies exactly 16*BIT_DIV cycles in SHIFT.

Reset
REQ-031 While reset=1 at an edge: FSM=IDLE, FIFO empty, pointers=0, shift register=0, divider=0, sat_flag=0, ovf_cnt=0.
REQ-032 Output values after reset: in_ready=1, sck=0, ws=0, sdo=0, sat_flag=0, ovf_cnt=0.
REQ-033 Reset mid-word aborts the word immediately; buffered samples are discarded.
REQ-034 in_data/in_valid ignored during reset cycles.

Verification
REQ-035 Basic: in_data=1000*2^31, one valid cycle -> 16 bits 0x03E8 MSB first on sdo, ws high for first bit only, 64 cycles in SHIFT, then IDLE.
REQ-036 Rounding: in_data=2^30 -> 0x0001; in_data=2^30-1 -> 0x0000; in_data=-(2^30) -> 0x0000; sat_flag stays 0.
REQ-037 Saturation: in_data=40000*2^31 -> 0x7FFF; in_data=-40000*2^31 -> 0x8000; sat_flag=1 from next cycle until reset.
REQ-038 Back-to-back: 3 samples on consecutive cycles -> 3 words serialized contiguously, 192 SHIFT cycles, ws pulses exactly 64 cycles apart, no IDLE between.
REQ-039 Full/overflow: 12 samples on consecutive cycles after reset -> in_ready low once count=8; ovf_cnt increments once per dropped valid cycle while full; after the first pop in_ready rises.
REQ-040 Reset mid-word: reset at bit index 7 with 4 samples buffered -> next cycle all outputs at reset values, in_ready=1, no further words emitted.

Source files
------------

// File: rtl/fir_out_serializer_if.sv
// Sample handshake and serial output pins of the FIR output serializer.
interface fir_out_serializer_if #(
    parameter int unsigned DATA_IN_WIDTH = 64
);
    logic [DATA_IN_WIDTH-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic                     sck;
    logic                     ws;
    logic                     sdo;
    logic                     sat_flag;
    logic [7:0]               ovf_cnt;

    modport master (
        output in_data, in_valid,
        input  in_ready, sck, ws, sdo, sat_flag, ovf_cnt
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, sck, ws, sdo, sat_flag, ovf_cnt
    );
endinterface

// File: rtl/fir_out_serializer.sv
// Rounds, saturates and buffers wide FIR samples, then shifts them out MSB first
// on a divided bit clock with a word-start strobe.
module fir_out_serializer #(
    parameter int unsigned DATA_IN_WIDTH  = 64,
    parameter int unsigned DATA_OUT_WIDTH = 16,
    parameter int unsigned SHIFT          = 31,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned BIT_DIV        = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    fir_out_serializer_if.slave  bus
);
    localparam int unsigned SUM_W = DATA_IN_WIDTH + 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DIV_W = $clog2(BIT_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_OUT_WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(DATA_OUT_WIDTH - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(FIFO_DEPTH);

    localparam logic signed [SUM_W-1:0] RND     = SUM_W'(1) << (SHIFT - 1);
    localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << (DATA_OUT_WIDTH - 1)) - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MAX = SAT_MAX[DATA_OUT_WIDTH-1:0];
    localparam logic [DATA_OUT_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    logic signed [SUM_W-1:0]    sum_c;
    logic signed [SUM_W-1:0]    scaled_c;
    logic [DATA_OUT_WIDTH-1:0]  word_c;
    logic                       sat_c;

    logic [DATA_OUT_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              rd_ptr;
    logic [CW-1:0]              count;
    logic                       full_c;
    logic                       empty_c;
    logic                       push_c;
    logic                       pop_c;
    logic                       sat_q;
    logic [7:0]                 ovf_q;

    state_t                     state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [DATA_OUT_WIDTH-1:0]  shreg_q, shreg_d;

    // Round half up with one guard bit so the offset add cannot wrap, then clamp.
    always_comb begin
        sum_c    = $signed({bus.in_data[DATA_IN_WIDTH-1], bus.in_data}) + RND;
        scaled_c = sum_c >>> SHIFT;
        word_c   = scaled_c[DATA_OUT_WIDTH-1:0];
        sat_c    = 1'b0;
        if (scaled_c > SAT_MAX) begin
            word_c = OUT_MAX;
            sat_c  = 1'b1;
        end else if (scaled_c < SAT_MIN) begin
            word_c = OUT_MIN;
            sat_c  = 1'b1;
        end
    end

    assign full_c       = (count == CNT_FULL);
    assign empty_c      = (count == '0);
    assign push_c       = bus.in_valid && !full_c;
    assign bus.in_ready = !full_c;
    assign bus.sat_flag = sat_q;
    assign bus.ovf_cnt  = ovf_q;

    // Sample storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= word_c;
        end
    end

    // FIFO bookkeeping plus sticky saturation and drop counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            sat_q  <= 1'b0;
            ovf_q  <= '0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_c && sat_c) begin
                sat_q <= 1'b1;
            end
            if (bus.in_valid && full_c && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
        end
    end

    // Serializer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // Next state and pin decode; the next word is chained in without a gap.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        pop_c   = 1'b0;
        bus.sck = 1'b0;
        bus.ws  = 1'b0;
        bus.sdo = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pop_c   = 1'b1;
                shreg_d = mem[rd_ptr];
                idx_d   = IDX_TOP;
                div_d   = '0;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                bus.sck = (div_q >= DIV_HALF);
                bus.ws  = (idx_q == IDX_TOP);
                bus.sdo = shreg_q[idx_q];
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (idx_q != '0) begin
                        idx_d = idx_q - IDX_W'(1);
                    end else if (!empty_c) begin
                        pop_c   = 1'b1;
                        shreg_d = mem[rd_ptr];
                        idx_d   = IDX_TOP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end
endmodule
